// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter
//   Arbitrates the single SDRAM command/address/data bus between the init,
//   auto-refresh, write and read engines. Refresh has fixed top priority;
//   writes and reads alternate when both are pending. A granted engine gets a
//   one-cycle enable pulse and owns the pins until it raises its end flag.
//
// Ports
//   sclk, s_rst                 clock, asynchronous active-high reset
//   flag_init_end               init engine done; leaves IDLE
//   init_cmd/init_addr          init engine pin values (driven in IDLE)
//   ref_req/ref_en/flag_ref_end refresh request, grant pulse, done
//   ref_cmd/ref_addr            refresh engine pin values
//   wr_req/wr_en/flag_wr_end    write request, grant pulse, done
//   wr_cmd/wr_addr/wr_bank/wr_data  write engine pin values
//   rd_req/rd_en/flag_rd_end    read request, grant pulse, done
//   rd_cmd/rd_addr/rd_bank      read engine pin values
//   sd_cmd/sdram_addr/sdram_bank/dq_out/dq_oe  SDRAM pin outputs
//   arb_state                   one-hot state (debug)
//   err_timeout                 forced-release pulse
//
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to force an engine off the bus
// after it has held it for TIMEOUT_CYC cycles without signalling its end flag.
// Without the macro err_timeout is tied 0 and the engines may hold forever.

module sdram_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned AW          = 12,
  parameter int unsigned BW          = 2,
  parameter int unsigned DW          = 16
) (
  input  logic          sclk,
  input  logic          s_rst,
  input  logic          flag_init_end,
  input  logic [3:0]    init_cmd,
  input  logic [AW-1:0] init_addr,
  input  logic          ref_req,
  output logic          ref_en,
  input  logic          flag_ref_end,
  input  logic [3:0]    ref_cmd,
  input  logic [AW-1:0] ref_addr,
  input  logic          wr_req,
  output logic          wr_en,
  input  logic          flag_wr_end,
  input  logic [3:0]    wr_cmd,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_bank,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_req,
  output logic          rd_en,
  input  logic          flag_rd_end,
  input  logic [3:0]    rd_cmd,
  input  logic [AW-1:0] rd_addr,
  input  logic [BW-1:0] rd_bank,
  output logic [3:0]    sd_cmd,
  output logic [AW-1:0] sdram_addr,
  output logic [BW-1:0] sdram_bank,
  output logic [DW-1:0] dq_out,
  output logic          dq_oe,
  output logic [4:0]    arb_state,
  output logic          err_timeout
);

  localparam logic [3:0] CmdNop = 4'b0111;

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StArbit = 5'b00010,
    StAref  = 5'b00100,
    StWrite = 5'b01000,
    StRead  = 5'b10000
  } state_e;

  if (TIMEOUT_CYC < 1) begin : g_param_check
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e state_q, state_d;
  logic   last_wr_q, last_wr_d;
  logic   ref_en_d, wr_en_d, rd_en_d;
  logic   busy, end_match, timeout;

  assign busy = (state_q == StAref) || (state_q == StWrite) || (state_q == StRead);

  // Only the end flag of the engine currently holding the bus counts.
  always_comb begin
    end_match = 1'b0;
    case (state_q)
      StAref:  end_match = flag_ref_end;
      StWrite: end_match = flag_wr_end;
      StRead:  end_match = flag_rd_end;
      default: end_match = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    ref_en_d  = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (flag_init_end) state_d = StArbit;
      end
      StArbit: begin
        if (ref_req) begin
          state_d  = StAref;
          ref_en_d = 1'b1;
        end else if (wr_req && (!rd_req || !last_wr_q)) begin
          // Write wins when alone, or when both pend and a read went last.
          state_d   = StWrite;
          wr_en_d   = 1'b1;
          last_wr_d = 1'b1;
        end else if (rd_req) begin
          state_d   = StRead;
          rd_en_d   = 1'b1;
          last_wr_d = 1'b0;
        end
      end
      StAref, StWrite, StRead: begin
        if (end_match || timeout) state_d = StArbit;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q   <= StIdle;
      last_wr_q <= 1'b0;
      ref_en    <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      ref_en    <= ref_en_d;
      wr_en     <= wr_en_d;
      rd_en     <= rd_en_d;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned   CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // cnt_q counts completed cycles in the granted state; the cycle that sees
  // CntLast is the TIMEOUT_CYC-th one, so release happens on its closing edge.
  assign timeout = busy && (cnt_q == CntLast);

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      // An end flag on the timeout edge is a normal completion.
      err_q <= timeout && !end_match;
      if (ref_en_d || wr_en_d || rd_en_d) begin
        cnt_q <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Pin mux follows the owner of the bus directly.
  always_comb begin
    sd_cmd     = CmdNop;
    sdram_addr = '0;
    sdram_bank = '0;
    dq_out     = '0;
    dq_oe      = 1'b0;
    case (state_q)
      StIdle: begin
        sd_cmd     = init_cmd;
        sdram_addr = init_addr;
      end
      StAref: begin
        sd_cmd     = ref_cmd;
        sdram_addr = ref_addr;
      end
      StWrite: begin
        sd_cmd     = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
        dq_out     = wr_data;
        dq_oe      = 1'b1;
      end
      StRead: begin
        sd_cmd     = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: ;
    endcase
  end

  assign arb_state = state_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Testbench for sdram_cmd_arbiter: directed scenarios plus a randomized run
// compared each cycle against a behavioural model of bus ownership.
module tb_sdram_cmd_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned BW = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;
`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic          sclk, s_rst, flag_init_end;
  logic [3:0]    init_cmd, ref_cmd, wr_cmd, rd_cmd, sd_cmd;
  logic [AW-1:0] init_addr, ref_addr, wr_addr, rd_addr, sdram_addr;
  logic [BW-1:0] wr_bank, rd_bank, sdram_bank;
  logic [DW-1:0] wr_data, dq_out;
  logic          ref_req, ref_en, flag_ref_end;
  logic          wr_req, wr_en, flag_wr_end;
  logic          rd_req, rd_en, flag_rd_end;
  logic          dq_oe, err_timeout;
  logic [4:0]    arb_state;

  sdram_cmd_arbiter #(.TIMEOUT_CYC(TO), .AW(AW), .BW(BW), .DW(DW)) dut (
    .sclk(sclk), .s_rst(s_rst), .flag_init_end(flag_init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
    .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
    .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .sd_cmd(sd_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .dq_out(dq_out), .dq_oe(dq_oe), .arb_state(arb_state), .err_timeout(err_timeout)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int checks = 0;
  int passes = 0;

  // Model: owner 0=init phase, 1=bus free, 2=refresh, 3=write, 4=read.
  int m_own;
  bit m_last_wr;
  int m_pulse;
  int m_cnt;
  bit m_err;

  function automatic void model_reset();
    m_own = 0; m_last_wr = 1'b0; m_pulse = 0; m_cnt = 0; m_err = 1'b0;
  endfunction

  function automatic void model_step();
    bit done;
    m_pulse = 0;
    m_err   = 1'b0;
    if (m_own == 0) begin
      if (flag_init_end) m_own = 1;
    end else if (m_own == 1) begin
      m_cnt = 0;
      if (ref_req) begin
        m_own = 2; m_pulse = 2;
      end else if (wr_req || rd_req) begin
        if (wr_req && rd_req) m_own = m_last_wr ? 4 : 3;
        else                  m_own = wr_req ? 3 : 4;
        m_pulse   = m_own;
        m_last_wr = (m_own == 3);
      end
    end else begin
      m_cnt++;
      done = (m_own == 2 && flag_ref_end) || (m_own == 3 && flag_wr_end) ||
             (m_own == 4 && flag_rd_end);
      if (done) m_own = 1;
      else if (TimeoutOn && m_cnt >= int'(TO)) begin
        m_own = 1; m_err = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge sclk);
    if (s_rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic clear_inputs();
    flag_init_end = 0; ref_req = 0; wr_req = 0; rd_req = 0;
    flag_ref_end = 0; flag_wr_end = 0; flag_rd_end = 0;
  endtask

  task automatic rand_pins();
    init_cmd = 4'($urandom); ref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
    init_addr = AW'($urandom); ref_addr = AW'($urandom);
    wr_addr = AW'($urandom); rd_addr = AW'($urandom);
    wr_bank = BW'($urandom); rd_bank = BW'($urandom); wr_data = DW'($urandom);
  endtask

  task automatic reset_and_init();
    clear_inputs();
    s_rst = 1; model_reset();
    tick(); tick();
    s_rst = 0;
    tick();
    flag_init_end = 1;
    tick();
    flag_init_end = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); rand_pins();
    s_rst = 1; model_reset();
    tick(); tick();
    checks++;
    if (arb_state !== 5'b00001) $display("FAIL reset_state: got %b want 00001", arb_state);
    else passes++;
    checks++;
    if ({ref_en, wr_en, rd_en, err_timeout} !== 4'b0)
      $display("FAIL reset_grants: got %b want 0000", {ref_en, wr_en, rd_en, err_timeout});
    else passes++;
    checks++;
    if ({sd_cmd, sdram_addr, sdram_bank, dq_oe} !== {init_cmd, init_addr, 2'b00, 1'b0})
      $display("FAIL reset_pins: cmd=%h addr=%h bank=%h oe=%b want cmd=%h addr=%h bank=0 oe=0",
               sd_cmd, sdram_addr, sdram_bank, dq_oe, init_cmd, init_addr);
    else passes++;
    s_rst = 0;
  endtask

  task automatic test_init();
    wr_req = 1; rd_req = 1; ref_req = 1;
    for (int c = 1; c < 20; c++) begin
      tick(); rand_pins(); #1;
      checks++;
      if (arb_state !== 5'b00001 || {ref_en, wr_en, rd_en} !== 3'b0 || sd_cmd !== init_cmd)
        $display("FAIL idle_hold c%0d: state=%b en=%b cmd=%h want 00001 000 %h",
                 c, arb_state, {ref_en, wr_en, rd_en}, sd_cmd, init_cmd);
      else passes++;
    end
    wr_req = 0; rd_req = 0; ref_req = 0; flag_init_end = 1;
    tick();
    flag_init_end = 0;
    checks++;
    if (arb_state !== 5'b00010 || sd_cmd !== 4'b0111 || sdram_addr !== '0 || sdram_bank !== '0)
      $display("FAIL init_exit: state=%b cmd=%h addr=%h bank=%h want 00010 7 0 0",
               arb_state, sd_cmd, sdram_addr, sdram_bank);
    else passes++;
  endtask

  task automatic test_ref_priority();
    ref_req = 1; wr_req = 1;
    tick();
    ref_req = 0;
    checks++;
    if (arb_state !== 5'b00100 || {ref_en, wr_en, rd_en} !== 3'b100 || sd_cmd !== ref_cmd)
      $display("FAIL ref_grant: state=%b en=%b cmd=%h want 00100 100 %h",
               arb_state, {ref_en, wr_en, rd_en}, sd_cmd, ref_cmd);
    else passes++;
    tick();
    checks++;
    if (arb_state !== 5'b00100 || ref_en !== 1'b0)
      $display("FAIL ref_pulse_width: state=%b ref_en=%b want 00100 0", arb_state, ref_en);
    else passes++;
    flag_ref_end = 1;
    tick();
    flag_ref_end = 0;
    checks++;
    if (arb_state !== 5'b00010 || {ref_en, wr_en, rd_en} !== 3'b0 || sd_cmd !== 4'b0111)
      $display("FAIL ref_release: state=%b en=%b cmd=%h want 00010 000 7",
               arb_state, {ref_en, wr_en, rd_en}, sd_cmd);
    else passes++;
    tick();
    checks++;
    if (arb_state !== 5'b01000 || {ref_en, wr_en, rd_en} !== 3'b010)
      $display("FAIL pending_wr_grant: state=%b en=%b want 01000 010", arb_state, {ref_en, wr_en, rd_en});
    else passes++;
    wr_req = 0; flag_wr_end = 1;
    tick();
    flag_wr_end = 0;
  endtask

  task automatic test_round_robin();
    bit is_wr;
    reset_and_init();
    wr_req = 1; rd_req = 1;
    for (int g = 0; g < 4; g++) begin
      is_wr = (g % 2 == 0);
      rand_pins();
      tick();
      checks++;
      if (arb_state !== (is_wr ? 5'b01000 : 5'b10000) || {wr_en, rd_en} !== {is_wr, !is_wr})
        $display("FAIL rr_grant g%0d: state=%b en=%b want %s", g, arb_state, {wr_en, rd_en},
                 is_wr ? "01000 10" : "10000 01");
      else passes++;
      for (int c = 1; c <= 4; c++) begin
        if (c > 1) begin
          tick();
          checks++;
          if ({ref_en, wr_en, rd_en} !== 3'b0)
            $display("FAIL rr_pulse g%0d c%0d: en=%b want 000", g, c, {ref_en, wr_en, rd_en});
          else passes++;
        end
        rand_pins(); #1;
        checks++;
        if (dq_oe !== is_wr || sdram_bank !== (is_wr ? wr_bank : rd_bank) ||
            sd_cmd !== (is_wr ? wr_cmd : rd_cmd) || dq_out !== (is_wr ? wr_data : DW'(0)))
          $display("FAIL rr_pins g%0d c%0d: oe=%b bank=%h cmd=%h dq=%h want oe=%b bank=%h cmd=%h",
                   g, c, dq_oe, sdram_bank, sd_cmd, dq_out, is_wr,
                   is_wr ? wr_bank : rd_bank, is_wr ? wr_cmd : rd_cmd);
        else passes++;
        if (c == 4) begin
          if (is_wr) flag_wr_end = 1;
          else flag_rd_end = 1;
        end
      end
      tick();
      flag_wr_end = 0; flag_rd_end = 0;
      checks++;
      if (arb_state !== 5'b00010 || dq_oe !== 1'b0 || sd_cmd !== 4'b0111)
        $display("FAIL rr_gap g%0d: state=%b oe=%b cmd=%h want 00010 0 7", g, arb_state, dq_oe, sd_cmd);
      else passes++;
    end
    wr_req = 0; rd_req = 0;
  endtask

  task automatic test_ignore_flag();
    rd_req = 1;
    tick();
    rd_req = 0; ref_req = 1; wr_req = 1; flag_wr_end = 1;
    tick();
    flag_wr_end = 0; flag_ref_end = 1;
    checks++;
    if (arb_state !== 5'b10000) $display("FAIL wr_end_ignored: state=%b want 10000", arb_state);
    else passes++;
    tick();
    flag_ref_end = 0;
    checks++;
    if (arb_state !== 5'b10000) $display("FAIL ref_end_ignored: state=%b want 10000", arb_state);
    else passes++;
    flag_rd_end = 1;
    tick();
    flag_rd_end = 0;
    checks++;
    if (arb_state !== 5'b00010) $display("FAIL rd_release: state=%b want 00010", arb_state);
    else passes++;
    tick();
    ref_req = 0;
    checks++;
    if (arb_state !== 5'b00100 || {ref_en, wr_en} !== 2'b10)
      $display("FAIL ref_before_wr: state=%b ref_en=%b wr_en=%b want 00100 1 0", arb_state, ref_en, wr_en);
    else passes++;
    flag_ref_end = 1;
    tick();
    flag_ref_end = 0;
    tick();
    checks++;
    if (arb_state !== 5'b01000 || wr_en !== 1'b1)
      $display("FAIL wr_after_ref: state=%b wr_en=%b want 01000 1", arb_state, wr_en);
    else passes++;
  endtask

  task automatic test_mid_reset();
    tick();
    s_rst = 1; #1;
    model_reset();
    checks++;
    if (arb_state !== 5'b00001 || {ref_en, wr_en, rd_en} !== 3'b0 || sd_cmd !== init_cmd)
      $display("FAIL async_reset: state=%b en=%b cmd=%h want 00001 000 %h",
               arb_state, {ref_en, wr_en, rd_en}, sd_cmd, init_cmd);
    else passes++;
    tick();
    s_rst = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (arb_state !== 5'b00001 || wr_en !== 1'b0)
        $display("FAIL post_reset_wait c%0d: state=%b wr_en=%b want 00001 0", c, arb_state, wr_en);
      else passes++;
    end
    flag_init_end = 1;
    tick();
    flag_init_end = 0;
    tick();
    checks++;
    if (arb_state !== 5'b01000 || wr_en !== 1'b1)
      $display("FAIL post_reset_grant: state=%b wr_en=%b want 01000 1", arb_state, wr_en);
    else passes++;
    wr_req = 0; flag_wr_end = 1;
    tick();
    flag_wr_end = 0;
  endtask

  task automatic test_timeout();
    wr_req = 1;
    tick();
    wr_req = 0;
    for (int c = 2; c <= int'(TO); c++) begin
      tick();
      checks++;
      if (arb_state !== 5'b01000 || err_timeout !== 1'b0)
        $display("FAIL hold_write c%0d: state=%b err=%b want 01000 0", c, arb_state, err_timeout);
      else passes++;
    end
`ifdef SDRAM_ARB_TIMEOUT_EN
    tick();
    checks++;
    if (arb_state !== 5'b00010 || err_timeout !== 1'b1)
      $display("FAIL timeout_fire: state=%b err=%b want 00010 1", arb_state, err_timeout);
    else passes++;
    tick();
    checks++;
    if (arb_state !== 5'b00010 || err_timeout !== 1'b0)
      $display("FAIL timeout_pulse: state=%b err=%b want 00010 0", arb_state, err_timeout);
    else passes++;
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (arb_state !== 5'b01000 || err_timeout !== 1'b0)
        $display("FAIL no_timeout c%0d: state=%b err=%b want 01000 0", c, arb_state, err_timeout);
      else passes++;
    end
    flag_wr_end = 1;
    tick();
    flag_wr_end = 0;
`endif
  endtask

  task automatic test_random();
    logic [8:0]  exp_ctrl;
    logic [34:0] exp_pins;
    reset_and_init();
    for (int i = 0; i < 600; i++) begin
      tick();
      s_rst = ($urandom_range(0, 149) == 0);
      if (s_rst) model_reset();
      ref_req = ($urandom_range(0, 9) == 0);
      wr_req = ($urandom_range(0, 2) != 0);
      rd_req = ($urandom_range(0, 2) != 0);
      flag_ref_end = ($urandom_range(0, 3) == 0);
      flag_wr_end = ($urandom_range(0, 3) == 0);
      flag_rd_end = ($urandom_range(0, 3) == 0);
      flag_init_end = ($urandom_range(0, 5) == 0);
      rand_pins();
      #1;
      exp_ctrl = {5'(1 << m_own), m_pulse == 2, m_pulse == 3, m_pulse == 4, m_err};
      case (m_own)
        0:       exp_pins = {init_cmd, init_addr, 2'b00, 16'h0, 1'b0};
        2:       exp_pins = {ref_cmd, ref_addr, 2'b00, 16'h0, 1'b0};
        3:       exp_pins = {wr_cmd, wr_addr, wr_bank, wr_data, 1'b1};
        4:       exp_pins = {rd_cmd, rd_addr, rd_bank, 16'h0, 1'b0};
        default: exp_pins = {4'b0111, 12'h0, 2'b00, 16'h0, 1'b0};
      endcase
      checks++;
      if ({arb_state, ref_en, wr_en, rd_en, err_timeout} !== exp_ctrl)
        $display("FAIL rand_ctrl i%0d: state/ref/wr/rd/err=%b want %b", i,
                 {arb_state, ref_en, wr_en, rd_en, err_timeout}, exp_ctrl);
      else passes++;
      checks++;
      if ({sd_cmd, sdram_addr, sdram_bank, dq_out, dq_oe} !== exp_pins)
        $display("FAIL rand_pins i%0d: cmd/addr/bank/dq/oe=%h want %h", i,
                 {sd_cmd, sdram_addr, sdram_bank, dq_out, dq_oe}, exp_pins);
      else passes++;
    end
    s_rst = 0;
  endtask

  initial begin
    s_rst = 1;
    clear_inputs();
    rand_pins();
    model_reset();
    test_reset();
    test_init();
    test_ref_priority();
    test_round_robin();
    test_ignore_flag();
    test_mid_reset();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Sequences shared access to the single SDRAM command/address/data bus between four sources: init, auto-refresh, write and read.
- Sits between the sdram_init/sdram_aref/write/read engines and the SDRAM pins.
- Grants one engine at a time with one-cycle enable pulses and waits for that engine's end flag.
- Priority is fixed for refresh; writes and reads share round-robin. A combinational mux drives the pins from the active engine.

Parameters:
- TIMEOUT_CYC, 1024: max cycles a granted engine may hold the bus before forced release (used only with ARB_TIMEOUT_EN).
- AW, 12: SDRAM address width.
- BW, 2: bank address width.
- DW, 16: data width.

Ports:
- sclk  in  1  system clock; all state on rising edge.
- s_rst  in  1  asynchronous, active-high reset.
- flag_init_end  in  1  init engine done.
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}.
- init_addr  in  AW  init address.
- ref_req  in  1  refresh request (level).
- ref_en  out  1  refresh grant pulse.
- flag_ref_end  in  1  refresh done.
- ref_cmd  in  4  refresh command.
- ref_addr  in  AW  refresh address.
- wr_req  in  1  write request (level).
- wr_en  out  1  write grant pulse.
- flag_wr_end  in  1  write done.
- wr_cmd  in  4  write command.
- wr_addr  in  AW  write address.
- wr_bank  in  BW  write bank.
- wr_data  in  DW  write data.
- rd_req  in  1  read request (level).
- rd_en  out  1  read grant pulse.
- flag_rd_end  in  1  read done.
- rd_cmd  in  4  read command.
- rd_addr  in  AW  read address.
- rd_bank  in  BW  read bank.
- sd_cmd  out  4  command to pins.
- sdram_addr  out  AW  address to pins.
- sdram_bank  out  BW  bank to pins.
- dq_out  out  DW  write data to pins.
- dq_oe  out  1  data bus output enable.
- arb_state  out  5  one-hot state, for debug.
- err_timeout  out  1  forced-release pulse (ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- States, one-hot: IDLE=5'b00001, ARBIT=5'b00010, AREF=5'b00100, WRITE=5'b01000, READ=5'b10000.
- Reset values: state=IDLE, ref_en=wr_en=rd_en=0, last_wr=0, err_timeout=0, timeout counter=0.
- IDLE: exits to ARBIT on the edge where flag_init_end=1. All requests are ignored in IDLE.
- ARBIT: evaluated each edge, in priority order:
  - ref_req=1 -> AREF, and ref_en=1 during the first AREF cycle.
  - else if wr_req and rd_req are both 1 -> grant the one not granted last (last_wr=1 -> READ, last_wr=0 -> WRITE).
  - else if wr_req -> WRITE; else if rd_req -> READ.
  - else stay in ARBIT.
- Grant pulses:
  - Registered; exactly one cycle wide; coincide with the first cycle of the granted state.
  - At most one pulse is high in any cycle.
- last_wr updates on grant only: 1 on a WRITE grant, 0 on a READ grant. Refresh grants leave it unchanged.
- AREF/WRITE/READ: return to ARBIT on the edge where the matching end flag is 1. Non-matching end flags are ignored.
- Minimum one ARBIT cycle (NOP on the pins) between consecutive grants.
- Requests arriving while another engine is granted are held by the requester and evaluated at the next ARBIT cycle. Refresh always wins that ARBIT cycle.
- Pin mux, combinational from state:
  - IDLE -> init_cmd/init_addr, bank 0.
  - AREF -> ref_cmd/ref_addr, bank 0.
  - WRITE -> wr_cmd/wr_addr/wr_bank.
  - READ -> rd_cmd/rd_addr/rd_bank.
  - ARBIT -> sd_cmd=4'b0111 (NOP), addr 0, bank 0.
- dq_oe=1 only in WRITE. dq_out=wr_data in WRITE, 0 otherwise.
- Reset asserted mid-operation: immediate return to IDLE with all grants 0. flag_init_end is required again before any grant.
- Unreachable or illegal state encoding -> IDLE on the next edge.

Optional Feature:
- Macro SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on every grant and increments each cycle in AREF/WRITE/READ.
  - If it reaches TIMEOUT_CYC with no matching end flag, the state is forced to ARBIT and err_timeout pulses 1 cycle on that transition.
  - An end flag on the same edge as the timeout counts as a normal end; no error.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Not defined: no counter; err_timeout tied 0; states wait forever for their end flag.

Test Plan:
- Release reset, pulse flag_init_end at cycle 20 -> arb_state goes 00001->00010 at cycle 21; sd_cmd=init_cmd before that, 4'b0111 after.
- In ARBIT, raise ref_req and wr_req together -> ref_en pulses 1 cycle, state AREF. flag_ref_end -> ARBIT for 1 cycle, then wr_en pulses and state WRITE.
- Hold wr_req=rd_req=1 continuously, ending each burst after 4 cycles -> grants alternate W,R,W,R; dq_oe=1 only during WRITE cycles; sdram_bank follows wr_bank/rd_bank.
- During READ, assert ref_req and pulse flag_wr_end -> flag ignored, state stays READ until flag_rd_end; then AREF is granted before any pending write.
- Assert s_rst for 1 cycle in the middle of WRITE -> all en outputs 0, state IDLE, sd_cmd=init_cmd, no grant until flag_init_end.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, grant WRITE and never send flag_wr_end -> after 8 cycles state ARBIT and err_timeout=1 for exactly 1 cycle; without the macro, state stays WRITE.
